// File: rtl/fib_seq_gen.sv
// Generalised Fibonacci FSMD: F(n) from seeds (seed0, seed1), one add per clock, optional saturation and abort.
// start accepted only while ready; OP lasts max(n,1) cycles, then a one-cycle done_tick.
module fib_seq_gen #(
    parameter int W        = 32,
    parameter int N_W      = 6,
    parameter int SATURATE = 0
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] n,
    input  logic [W-1:0]   seed0,
    input  logic [W-1:0]   seed1,
    input  logic           abort,
    output logic           ready,
    output logic           busy,
    output logic           done_tick,
    output logic           ovf,
    output logic [W-1:0]   f
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   t0_reg, t0_next;
    logic [W-1:0]   t1_reg, t1_next;
    logic [N_W-1:0] cnt_reg, cnt_next;
    logic           ovf_reg, ovf_next;
    logic [W:0]     sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            t0_reg    <= '0;
            t1_reg    <= '0;
            cnt_reg   <= '0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            t0_reg    <= t0_next;
            t1_reg    <= t1_next;
            cnt_reg   <= cnt_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Carry-out of this sum is the overflow indicator.
    assign sum = {1'b0, t0_reg} + {1'b0, t1_reg};

    always_comb begin
        state_next = state_reg;
        t0_next    = t0_reg;
        t1_next    = t1_reg;
        cnt_next   = cnt_reg;
        ovf_next   = ovf_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    t0_next    = seed0;
                    t1_next    = seed1;
                    cnt_next   = n;
                    ovf_next   = 1'b0;
                    state_next = OP;
                end
            end
            OP: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    t1_next    = t0_reg;
                    state_next = DONE;
                end else if (cnt_reg == N_W'(1)) begin
                    state_next = DONE;
                end else begin
                    t0_next  = t1_reg;
                    cnt_next = cnt_reg - N_W'(1);
                    t1_next  = (SATURATE != 0 && sum[W]) ? '1 : sum[W-1:0];
                    if (sum[W]) begin
                        ovf_next = 1'b1;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ready     = (state_reg == IDLE);
    assign busy      = (state_reg == OP);
    assign done_tick = (state_reg == DONE);
    assign ovf       = ovf_reg;
    assign f         = t1_reg;

endmodule
